// File: rtl/fifo_rd_stream_pkg.sv
// Shared helpers for the FIFO read-side stream adapter.
// Holds the clog2 helper and parameter legality limits.
package fifo_rd_stream_pkg;

   localparam int MIN_READ_LATENCY = 1;
   localparam int MAX_READ_LATENCY = 4;
   localparam int MIN_BUF_DEPTH    = 2;
   localparam int MAX_BUF_DEPTH    = 16;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

   function automatic bit params_legal(
      input int read_latency,
      input int buf_depth
   );
      return (read_latency >= MIN_READ_LATENCY)
          && (read_latency <= MAX_READ_LATENCY)
          && (buf_depth >= MIN_BUF_DEPTH)
          && (buf_depth <= MAX_BUF_DEPTH)
          && is_pow2(buf_depth);
   endfunction

endpackage

// File: rtl/fifo_rd_credit.sv
// Read-issue credit logic: strobe generation and latency tracking.
// Ports: clk, rst, fifo_empty, occ, pop in; fifo_rd_en, capture out.
module fifo_rd_credit
   import fifo_rd_stream_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int BUF_DEPTH    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fifo_empty,
   input  logic [clog2(BUF_DEPTH):0] occ,
   input  logic                     pop,
   output logic                     fifo_rd_en,
   output logic                     capture
);

   localparam int OW = clog2(BUF_DEPTH) + 1;
   localparam int SW = OW + 1;
   localparam logic [SW-1:0] DEPTH = SW'(BUF_DEPTH);

   // One bit per outstanding strobe; the top bit marks
   // the cycle in which the FIFO presents that word.
   logic [READ_LATENCY-1:0] lat_sr_q;
   logic [READ_LATENCY-1:0] lat_sr_d;
   logic [OW-1:0]           inflight;
   logic [SW-1:0]           credit_used;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         inflight = inflight + OW'(lat_sr_q[i]);
      end
      credit_used = SW'(occ) + SW'(inflight);
      // A full credit pool may still issue when a pop
      // frees a slot this same cycle.
      fifo_rd_en = !rst && !fifo_empty
                && ((credit_used < DEPTH)
                 || ((credit_used == DEPTH) && pop));
      lat_sr_d = (lat_sr_q << 1)
               | READ_LATENCY'(fifo_rd_en);
      capture  = lat_sr_q[READ_LATENCY-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_sr_q <= '0;
      end else begin
         lat_sr_q <= lat_sr_d;
      end
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read side to valid/ready stream adapter with local buffer.
// Ports: clk, rst, fifo_empty/fifo_rd_en/fifo_data, m_valid/m_ready/m_data, level.
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int BYTE_WIDTH   = 1,
   parameter int READ_LATENCY = 1,
   parameter int BUF_DEPTH    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      fifo_empty,
   output logic                      fifo_rd_en,
   input  logic [BYTE_WIDTH*8-1:0]   fifo_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [BYTE_WIDTH*8-1:0]   m_data,
   output logic [clog2(BUF_DEPTH):0] level
);

   localparam int DW = BYTE_WIDTH * 8;
   localparam int AW = clog2(BUF_DEPTH);
   localparam int OW = AW + 1;

   if (!params_legal(READ_LATENCY, BUF_DEPTH)) begin : g_bad_params
      $error("fifo_rd_stream: illegal READ_LATENCY or BUF_DEPTH");
   end

   logic [DW-1:0] buf_q [BUF_DEPTH];
   logic [DW-1:0] buf_d [BUF_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] wr_ptr_d;
   logic [AW-1:0] rd_ptr_q;
   logic [AW-1:0] rd_ptr_d;
   logic [OW-1:0] occ_q;
   logic [OW-1:0] occ_d;
   logic          capture;
   logic          pop;

   fifo_rd_credit #(
      .READ_LATENCY (READ_LATENCY),
      .BUF_DEPTH    (BUF_DEPTH)
   ) u_credit (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .occ        (occ_q),
      .pop        (pop),
      .fifo_rd_en (fifo_rd_en),
      .capture    (capture)
   );

   // Outputs depend on registered state only.
   assign m_valid = (occ_q != '0);
   assign m_data  = buf_q[rd_ptr_q];
   assign level   = occ_q;
   assign pop     = m_valid && m_ready;

   always_comb begin
      buf_d    = buf_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (capture) begin
         buf_d[wr_ptr_q] = fifo_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Capture and pop together leave occ unchanged;
      // the popped word is the old head entry.
      unique case (1'b1)
         capture && !pop: occ_d = occ_q + 1'b1;
         pop && !capture: occ_d = occ_q - 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         buf_q    <= buf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

endmodule
